// File: rtl/gci_std_display_pkg.sv
// Shared definitions for the display register bridge: register map, FSM encoding, request layout.
package gci_std_display_pkg;

  localparam logic [3:0] RESOLUT = 4'h0;
  localparam logic [3:0] MODE    = 4'h2;
  localparam logic [3:0] SIZE    = 4'h3;

  localparam int DEF_RD_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// In-order synchronous FIFO; head data valid one cycle after the push (no bypass).
// Full flag is registered, so a push is refused while full even if a pop happens that cycle.
module gci_std_display_sync_fifo #(
  parameter int P_WIDTH   = 37,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iPUSH,
  input  logic [P_WIDTH-1:0]   iDATA,
  input  logic                 iPOP,
  output logic [P_WIDTH-1:0]   oDATA,
  output logic                 oFULL,
  output logic                 oEMPTY,
  output logic [P_DEPTH_N:0]   oCOUNT
);

  localparam int CNT_W = P_DEPTH_N + 1;

  logic [P_WIDTH-1:0]   mem [P_DEPTH];
  logic [P_DEPTH_N-1:0] wptr;
  logic [P_DEPTH_N-1:0] rptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 full;
  logic                 push_ok;
  logic                 pop_ok;

  assign push_ok = iPUSH && !full;
  assign pop_ok  = iPOP && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + 1'b1;
    else if (!push_ok && pop_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop_ok)
        rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(P_DEPTH));
    end
  end

  // Storage needs no reset: the pointers/count decide what is valid.
  always_ff @(posedge iCLOCK) begin
    if (push_ok)
      mem[wptr] <= iDATA;
  end

  assign oDATA  = mem[rptr];
  assign oFULL  = full;
  assign oEMPTY = (count == '0);
  assign oCOUNT = count;

endmodule

// File: rtl/gci_std_display_reg_bridge.sv
// Host-to-register bridge: queued requests, write strobe at N+2, read response at N+4 (or timeout).
// Host stalls on oREQ_BUSY (queue full); the response holds while iRSP_BUSY is high.
module gci_std_display_reg_bridge
  import gci_std_display_pkg::*;
#(
  parameter int P_FIFO_DEPTH   = 4,
  parameter int P_FIFO_DEPTH_N = 2,
  parameter int P_RD_TIMEOUT   = DEF_RD_TIMEOUT
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [3:0]  iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oRSP_VALID,
  input  logic        iRSP_BUSY,
  output logic [31:0] oRSP_DATA,
  output logic        oRSP_ERR,
  output logic        oREG_WR_VALID,
  output logic [3:0]  oREG_WR_ADDR,
  output logic [31:0] oREG_WR_DATA,
  output logic        oREG_RD_VALID,
  input  logic        iREG_RD_BUSY,
  output logic [3:0]  oREG_RD_ADDR,
  input  logic        iREG_RD_VALID,
  output logic        oREG_RD_BUSY,
  input  logic [31:0] iREG_RD_DATA
);

  state_t      state, state_nxt;
  req_t        req_in, head;
  logic        fifo_full, fifo_empty, pop;
  logic [P_FIFO_DEPTH_N:0] fifo_count_unused;

  logic        wr_valid_nxt, rd_valid_nxt, rsp_err_nxt;
  logic [3:0]  wr_addr_nxt, rd_addr_nxt;
  logic [31:0] wr_data_nxt, rsp_data_nxt;
  logic [4:0]  wait_cnt, wait_nxt;

  assign req_in = '{rw: iREQ_RW, addr: iREQ_ADDR, data: iREQ_DATA};

  gci_std_display_sync_fifo #(
    .P_WIDTH   ($bits(req_t)),
    .P_DEPTH   (P_FIFO_DEPTH),
    .P_DEPTH_N (P_FIFO_DEPTH_N)
  ) u_req_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (iREQ_VALID && !iRESET_SYNC),
    .iDATA       (req_in),
    .iPOP        (pop),
    .oDATA       (head),
    .oFULL       (fifo_full),
    .oEMPTY      (fifo_empty),
    .oCOUNT      (fifo_count_unused)
  );

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = oREG_WR_ADDR;
    wr_data_nxt  = oREG_WR_DATA;
    rd_valid_nxt = 1'b0;
    rd_addr_nxt  = oREG_RD_ADDR;
    rsp_data_nxt = oRSP_DATA;
    rsp_err_nxt  = oRSP_ERR;
    wait_nxt     = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head.rw) begin
            pop          = 1'b1;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = head.addr;
            wr_data_nxt  = head.data;
          end else if (!iREG_RD_BUSY) begin
            pop          = 1'b1;
            rd_valid_nxt = 1'b1;
            rd_addr_nxt  = head.addr;
            wait_nxt     = 5'd0;
            state_nxt    = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (iREG_RD_VALID) begin
          rsp_data_nxt = iREG_RD_DATA;
          rsp_err_nxt  = 1'b0;
          state_nxt    = ST_RSP;
        end else if (wait_cnt == 5'(P_RD_TIMEOUT - 1)) begin
          rsp_data_nxt = 32'h0;
          rsp_err_nxt  = 1'b1;
          state_nxt    = ST_RSP;
        end else begin
          wait_nxt = wait_cnt + 5'd1;
        end
      end
      ST_RSP: begin
        // No pop on the handshake cycle; the next request starts from IDLE.
        if (!iRSP_BUSY)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state         <= ST_IDLE;
      wait_cnt      <= 5'd0;
      oREG_WR_VALID <= 1'b0;
      oREG_WR_ADDR  <= 4'h0;
      oREG_WR_DATA  <= 32'h0;
      oREG_RD_VALID <= 1'b0;
      oREG_RD_ADDR  <= 4'h0;
      oRSP_DATA     <= 32'h0;
      oRSP_ERR      <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      oREG_WR_VALID <= wr_valid_nxt;
      oREG_WR_ADDR  <= wr_addr_nxt;
      oREG_WR_DATA  <= wr_data_nxt;
      oREG_RD_VALID <= rd_valid_nxt;
      oREG_RD_ADDR  <= rd_addr_nxt;
      oRSP_DATA     <= rsp_data_nxt;
      oRSP_ERR      <= rsp_err_nxt;
    end
  end

  assign oREQ_BUSY    = fifo_full;
  assign oRSP_VALID   = (state == ST_RSP);
  assign oREG_RD_BUSY = (state == ST_RSP);

endmodule

// File: tb/tb_gci_std_display_reg_bridge.sv
// Directed bench for the display register bridge; cycle k is sampled 1ns after its opening edge.
module tb_gci_std_display_reg_bridge;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iREQ_VALID, iREQ_RW, iRSP_BUSY, iREG_RD_BUSY, iREG_RD_VALID;
  logic [3:0]  iREQ_ADDR;
  logic [31:0] iREQ_DATA, iREG_RD_DATA;
  logic        oREQ_BUSY, oRSP_VALID, oRSP_ERR, oREG_WR_VALID, oREG_RD_VALID, oREG_RD_BUSY;
  logic [31:0] oRSP_DATA, oREG_WR_DATA;
  logic [3:0]  oREG_WR_ADDR, oREG_RD_ADDR;

  int n_chk = 0;
  int n_err = 0;

  always #5 iCLOCK = ~iCLOCK;

  gci_std_display_reg_bridge #(
    .P_FIFO_DEPTH   (4),
    .P_FIFO_DEPTH_N (2),
    .P_RD_TIMEOUT   (16)
  ) dut (
    .iCLOCK        (iCLOCK),
    .iRESET_SYNC   (iRESET_SYNC),
    .iREQ_VALID    (iREQ_VALID),
    .oREQ_BUSY     (oREQ_BUSY),
    .iREQ_RW       (iREQ_RW),
    .iREQ_ADDR     (iREQ_ADDR),
    .iREQ_DATA     (iREQ_DATA),
    .oRSP_VALID    (oRSP_VALID),
    .iRSP_BUSY     (iRSP_BUSY),
    .oRSP_DATA     (oRSP_DATA),
    .oRSP_ERR      (oRSP_ERR),
    .oREG_WR_VALID (oREG_WR_VALID),
    .oREG_WR_ADDR  (oREG_WR_ADDR),
    .oREG_WR_DATA  (oREG_WR_DATA),
    .oREG_RD_VALID (oREG_RD_VALID),
    .iREG_RD_BUSY  (iREG_RD_BUSY),
    .oREG_RD_ADDR  (oREG_RD_ADDR),
    .iREG_RD_VALID (iREG_RD_VALID),
    .oREG_RD_BUSY  (oREG_RD_BUSY),
    .iREG_RD_DATA  (iREG_RD_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic rw, input logic [3:0] a, input logic [31:0] d);
    iREQ_VALID = v;
    iREQ_RW    = rw;
    iREQ_ADDR  = a;
    iREQ_DATA  = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_busy"}, oREQ_BUSY, 0);
    chk({tag, "_rsp_vld"},  oRSP_VALID, 0);
    chk({tag, "_rsp_dat"},  oRSP_DATA, 0);
    chk({tag, "_rsp_err"},  oRSP_ERR, 0);
    chk({tag, "_wr_vld"},   oREG_WR_VALID, 0);
    chk({tag, "_wr_addr"},  oREG_WR_ADDR, 0);
    chk({tag, "_wr_dat"},   oREG_WR_DATA, 0);
    chk({tag, "_rd_vld"},   oREG_RD_VALID, 0);
    chk({tag, "_rd_addr"},  oREG_RD_ADDR, 0);
    chk({tag, "_rd_busy"},  oREG_RD_BUSY, 0);
  endtask

  logic [31:0] burst_dat [4];

  initial begin
    burst_dat = '{32'h5, 32'h6, 32'h7, 32'h4};
    iRESET_SYNC   = 1'b1;
    iRSP_BUSY     = 1'b0;
    iREG_RD_BUSY  = 1'b0;
    iREG_RD_VALID = 1'b0;
    iREG_RD_DATA  = 32'h0;
    // A request offered during reset must be ignored.
    drive_req(1'b1, 1'b1, 4'h2, 32'h99);
    repeat (3) tick;
    chk_all_zero("reset");
    iRESET_SYNC = 1'b0;
    drive_req(1'b0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_req_ignored", oREG_WR_VALID, 0);
      tick;
    end

    // Write burst: strobes at N+2..N+5 in order, never busy.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive_req(1'b1, 1'b1, MODE_ADDR(), burst_dat[i]);
      else       drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      chk("burst_busy", oREQ_BUSY, 0);
      chk("burst_wr_vld", oREG_WR_VALID, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        chk("burst_wr_dat", oREG_WR_DATA, burst_dat[i-2]);
        chk("burst_wr_addr", oREG_WR_ADDR, 4'h2);
      end
      tick;
    end

    // Read addr 3, data at N+3, response at N+4 held 3 extra cycles by iRSP_BUSY.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive_req(1'b1, 1'b0, 4'h3, 32'h0);
      else        drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      iREG_RD_VALID = (i == 3);
      iREG_RD_DATA  = (i == 3) ? 32'd307200 : 32'hDEAD;
      iRSP_BUSY     = (i < 7);
      chk("rd_rd_vld", oREG_RD_VALID, (i == 2));
      if (i >= 2) chk("rd_rd_addr", oREG_RD_ADDR, 4'h3);
      chk("rd_rsp_vld", oRSP_VALID, (i >= 4 && i <= 7));
      chk("rd_rd_busy", oREG_RD_BUSY, (i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) begin
        chk("rd_rsp_dat", oRSP_DATA, 32'h0004B000);
        chk("rd_rsp_err", oRSP_ERR, 0);
      end
      tick;
    end
    iREG_RD_VALID = 1'b0;
    iRSP_BUSY     = 1'b0;

    // Timeout: RD_WAIT at N+2..N+17, error response at N+18.
    for (int i = 0; i < 20; i++) begin
      if (i == 0) drive_req(1'b1, 1'b0, 4'h0, 32'h0);
      else        drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      chk("to_rsp_vld", oRSP_VALID, (i == 18));
      if (i == 18) begin
        chk("to_rsp_dat", oRSP_DATA, 32'h0);
        chk("to_rsp_err", oRSP_ERR, 1);
      end
      tick;
    end

    // Ordering: a write queued behind a read waits for the response handshake.
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      drive_req(1'b1, 1'b0, 4'h2, 32'h0);
      else if (i == 1) drive_req(1'b1, 1'b1, 4'h0, 32'hAB);
      else             drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      iREG_RD_VALID = (i == 3);
      iREG_RD_DATA  = 32'h11;
      iRSP_BUSY     = (i < 6);
      chk("ord_rsp_vld", oRSP_VALID, (i >= 4 && i <= 6));
      chk("ord_wr_vld", oREG_WR_VALID, (i == 8));
      if (i == 4) chk("ord_rsp_dat", oRSP_DATA, 32'h11);
      if (i == 8) begin
        chk("ord_wr_dat", oREG_WR_DATA, 32'hAB);
        chk("ord_wr_addr", oREG_WR_ADDR, 4'h0);
      end
      tick;
    end
    iREG_RD_VALID = 1'b0;
    iRSP_BUSY     = 1'b0;

    // Fill: stalled read, four writes fill the queue, fifth held until a slot frees.
    for (int i = 0; i < 27; i++) begin
      if (i == 0)                drive_req(1'b1, 1'b0, 4'h3, 32'h0);
      else if (i <= 4)           drive_req(1'b1, 1'b1, 4'h1, 32'h100 + i);
      else if (i <= 20)          drive_req(1'b1, 1'b1, 4'h1, 32'h105);
      else                       drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      chk("fill_busy", oREQ_BUSY, (i >= 5 && i <= 19));
      chk("fill_wr_vld", oREG_WR_VALID, (i >= 20 && i <= 24));
      if (i >= 20 && i <= 24) chk("fill_wr_dat", oREG_WR_DATA, 32'h100 + (i - 19));
      chk("fill_rsp_vld", oRSP_VALID, (i == 18));
      if (i == 18) chk("fill_rsp_err", oRSP_ERR, 1);
      tick;
    end

    // Reset mid-read with writes queued: nothing survives, late read data is ignored.
    for (int i = 0; i < 13; i++) begin
      if (i == 0)                drive_req(1'b1, 1'b0, 4'h3, 32'h0);
      else if (i == 1 || i == 2) drive_req(1'b1, 1'b1, 4'h2, 32'h55);
      else if (i == 8)           drive_req(1'b1, 1'b1, 4'h4, 32'h66);
      else                       drive_req(1'b0, 1'b0, 4'h0, 32'h0);
      iRESET_SYNC   = (i == 4 || i == 5);
      iREG_RD_VALID = (i == 5 || i == 6);
      iREG_RD_DATA  = 32'h77;
      if (i == 6) chk_all_zero("rstrd");
      if (i >= 5) begin
        chk("rstrd_rsp_vld", oRSP_VALID, 0);
        chk("rstrd_rd_vld", oREG_RD_VALID, 0);
        chk("rstrd_wr_vld", oREG_WR_VALID, (i == 10));
      end
      if (i == 10) chk("rstrd_wr_dat", oREG_WR_DATA, 32'h66);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  function automatic logic [3:0] MODE_ADDR();
    return 4'h2;
  endfunction

endmodule
